// File: rtl/capture_pkg.sv
// Shared types and helpers for the RAMqueue write-side capture controller.
package capture_pkg;

  localparam int unsigned ENTRIES_DEFAULT = 384;
  localparam int unsigned AW_DEFAULT      = 9;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  // Circular increment over 0..entries-1.
  function automatic int unsigned wrap_inc(input int unsigned addr,
                                           input int unsigned entries = ENTRIES_DEFAULT);
    return (addr >= entries - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Circular-buffer write controller: fills the sample RAMs, arms on enough history,
// stops trig_pos samples after a qualified trigger and freezes waddr for the dump.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEFAULT,
  parameter int unsigned AW      = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic          run,
  input  logic          capture_done,
  input  logic          triggered,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          capturing,
  output logic          set_capture_done
);

  localparam logic [AW-1:0] LastAddr = AW'(ENTRIES - 1);
  localparam logic [AW:0]   Full     = (AW + 1)'(ENTRIES);

  state_t        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] trig_cnt_q, trig_cnt_d;
  logic [AW:0]   smpl_cnt_q, smpl_cnt_d;
  logic          armed_q, armed_d;
  logic          latched_q, latched_d;
  logic          scd_q, scd_d;
  logic          cd_prev_q;
  logic [AW-1:0] trig_pos_eff;

  assign trig_pos_eff = (trig_pos > LastAddr) ? LastAddr : trig_pos;

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    trig_cnt_d = trig_cnt_q;
    smpl_cnt_d = smpl_cnt_q;
    armed_d    = armed_q;
    latched_d  = latched_q;
    we         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run && !capture_done) begin
          state_d    = CAPTURE;
          waddr_d    = '0;
          smpl_cnt_d = '0;
          trig_cnt_d = '0;
          latched_d  = 1'b0;
        end
      end
      CAPTURE: begin
        we = wrt_smpl;
        if (wrt_smpl) begin
          waddr_d = AW'(wrap_inc(32'(waddr_q), ENTRIES));
          if (smpl_cnt_q != Full) smpl_cnt_d = smpl_cnt_q + 1'b1;
          // Enough history once the post-trigger window would fill the rest of the buffer.
          if ((smpl_cnt_d + {1'b0, trig_pos_eff}) >= Full) armed_d = 1'b1;
        end
        if (latched_q) begin
          if (wrt_smpl) begin
            trig_cnt_d = trig_cnt_q + 1'b1;
            if (trig_cnt_d >= trig_pos_eff) state_d = DONE;
          end
        end else if (triggered && armed_q) begin
          latched_d = 1'b1;
          if (trig_pos_eff == '0) state_d = DONE;
        end
        if (!run) state_d = IDLE;
        if (state_d != CAPTURE) armed_d = 1'b0;
      end
      DONE: begin
        // cmd_cfg acknowledges the dump by dropping capture_done.
        if (cd_prev_q && !capture_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    scd_d = (state_q == CAPTURE) && (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      trig_cnt_q <= '0;
      smpl_cnt_q <= '0;
      armed_q    <= 1'b0;
      latched_q  <= 1'b0;
      scd_q      <= 1'b0;
      cd_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      trig_cnt_q <= trig_cnt_d;
      smpl_cnt_q <= smpl_cnt_d;
      armed_q    <= armed_d;
      latched_q  <= latched_d;
      scd_q      <= scd_d;
      cd_prev_q  <= capture_done;
    end
  end

  assign waddr            = waddr_q;
  assign armed            = armed_q;
  assign capturing        = (state_q == CAPTURE);
  assign set_capture_done = scd_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a sample-count model checked every cycle.
module tb_capture_ctrl;

  localparam int ENTRIES = 384;
  localparam int AW      = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wrt_smpl = 1'b0;
  logic          run = 1'b0;
  logic          capture_done = 1'b0;
  logic          triggered = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          capturing;
  logic          set_capture_done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  capture_ctrl #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wrt_smpl         (wrt_smpl),
    .run              (run),
    .capture_done     (capture_done),
    .triggered        (triggered),
    .trig_pos         (trig_pos),
    .we               (we),
    .waddr            (waddr),
    .armed            (armed),
    .capturing        (capturing),
    .set_capture_done (set_capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 capturing, 2 done. Address is simply writes mod ENTRIES.
  int m_phase = 0;
  int m_writes = 0;
  int m_trig_at = -1;
  bit m_armed = 0;
  bit m_scd = 0;
  bit m_cd_prev = 0;

  always @(posedge clk) begin
    int tpe;
    int held;
    bit done;
    if (!rst_n) begin
      m_phase = 0; m_writes = 0; m_trig_at = -1;
      m_armed = 0; m_scd = 0; m_cd_prev = 0;
    end else begin
      done  = 0;
      m_scd = 0;
      tpe   = (int'(trig_pos) > ENTRIES - 1) ? ENTRIES - 1 : int'(trig_pos);
      case (m_phase)
        0: if (run && !capture_done) begin
          m_phase = 1; m_writes = 0; m_trig_at = -1;
        end
        1: begin
          if (wrt_smpl) m_writes++;
          if (!run) begin
            m_phase = 0; m_armed = 0;
          end else begin
            if (m_trig_at < 0 && triggered && m_armed) begin
              if (tpe == 0) done = 1;
              else m_trig_at = m_writes;
            end else if (m_trig_at >= 0 && wrt_smpl && (m_writes - m_trig_at) >= tpe) begin
              done = 1;
            end
            held = (m_writes < ENTRIES) ? m_writes : ENTRIES;
            if (wrt_smpl && held + tpe >= ENTRIES) m_armed = 1;
            if (done) begin
              m_phase = 2; m_armed = 0; m_scd = 1;
            end
          end
        end
        default: if (m_cd_prev && !capture_done) m_phase = 0;
      endcase
      m_cd_prev = capture_done;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we", 32'(we), 32'(m_phase == 1 && wrt_smpl));
      chk("waddr", 32'(waddr), 32'(m_writes % ENTRIES));
      chk("armed", 32'(armed), 32'(m_armed));
      chk("capturing", 32'(capturing), 32'(m_phase == 1));
      chk("set_capture_done", 32'(set_capture_done), 32'(m_scd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      wrt_smpl = 1'b1;
      tick();
      wrt_smpl = 1'b0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    chk_en = 1;
    chk("rst waddr", 32'(waddr), 0);
    chk("rst armed", 32'(armed), 0);
    chk("rst capturing", 32'(capturing), 0);
    chk("rst scd", 32'(set_capture_done), 0);
    rst_n = 1'b1;

    // Long capture, early trigger ignored, arming and wrap.
    trig_pos = 9'd100;
    run = 1'b1;
    tick();
    chk("enter capturing", 32'(capturing), 1);
    wr(10, 4);
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    wr(273, 4);
    chk("armed after 283", 32'(armed), 0);
    wr(1, 4);
    chk("armed after 284", 32'(armed), 1);
    wr(99, 4);
    chk("waddr 383", 32'(waddr), 383);
    wr(1, 4);
    chk("waddr wrap", 32'(waddr), 0);
    wr(50, 2);
    chk("waddr 50", 32'(waddr), 50);
    chk("still capturing", 32'(capturing), 1);

    // Trigger at waddr 50, 100 more writes.
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    wr(99, 2);
    chk("capturing at 99 post", 32'(capturing), 1);
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    chk("done capturing", 32'(capturing), 0);
    chk("done pulse", 32'(set_capture_done), 1);
    chk("done waddr", 32'(waddr), 150);
    tick();
    chk("pulse single", 32'(set_capture_done), 0);
    chk("waddr frozen", 32'(waddr), 150);

    // Dump acknowledge.
    capture_done = 1'b1;
    repeat (2) tick();
    chk("done holds", 32'(capturing), 0);
    run = 1'b0;
    capture_done = 1'b0;
    repeat (2) tick();
    chk("idle waddr", 32'(waddr), 150);

    // trig_pos = 0: trigger completes immediately.
    trig_pos = '0;
    run = 1'b1;
    tick();
    chk("restart waddr", 32'(waddr), 0);
    wr(383, 0);
    chk("tp0 armed 383", 32'(armed), 0);
    wr(1, 0);
    chk("tp0 armed 384", 32'(armed), 1);
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    chk("tp0 done", 32'(capturing), 0);
    chk("tp0 pulse", 32'(set_capture_done), 1);
    chk("tp0 waddr", 32'(waddr), 0);
    tick();
    capture_done = 1'b1;
    tick();
    run = 1'b0;
    capture_done = 1'b0;
    repeat (2) tick();

    // Abort and restart.
    trig_pos = 9'd100;
    run = 1'b1;
    tick();
    wr(20, 1);
    chk("abort pre waddr", 32'(waddr), 20);
    run = 1'b0;
    tick();
    chk("abort capturing", 32'(capturing), 0);
    chk("abort waddr", 32'(waddr), 20);
    chk("abort scd", 32'(set_capture_done), 0);
    run = 1'b1;
    tick();
    chk("rerun capturing", 32'(capturing), 1);
    chk("rerun waddr", 32'(waddr), 0);
    chk("rerun armed", 32'(armed), 0);

    // Clamped trig_pos arms on first write, then reset mid-capture.
    trig_pos = 9'd500;
    wr(1, 1);
    chk("clamp armed", 32'(armed), 1);
    wr(5, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst waddr", 32'(waddr), 0);
    chk("midrst armed", 32'(armed), 0);
    chk("midrst capturing", 32'(capturing), 0);
    chk("midrst we", 32'(we), 0);
    chk("midrst scd", 32'(set_capture_done), 0);
    run = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
